// File: rtl/display_mux_7seg.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display (format M.SS.d).
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zeros on digits 3 and 2.
module display_mux_7seg #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] decimo,
  input  logic [3:0] uni_segundo,
  input  logic [3:0] dec_segundo,
  input  logic [3:0] minuto,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {PH_BLANK = 1'b0, PH_SHOW = 1'b1} phase_t;

  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       idx_r;
  logic [15:0]      snap_r;
  logic             first_r;

  phase_t     phase_s;
  logic       wrap_s;
  logic [3:0] digit_s;
  logic       blank_digit_s;
  logic [6:0] seg_nx_s;
  logic       dp_nx_s;
  logic [3:0] an_nx_s;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Slot phase, selected digit and next-cycle output values.
  always_comb begin
    wrap_s  = (cnt_r == CNT_W'(REFRESH_DIV - 1));
    phase_s = (cnt_r < CNT_W'(BLANK_CYCLES)) ? PH_BLANK : PH_SHOW;
    case (idx_r)
      2'd0:    digit_s = snap_r[3:0];
      2'd1:    digit_s = snap_r[7:4];
      2'd2:    digit_s = snap_r[11:8];
      2'd3:    digit_s = snap_r[15:12];
      default: digit_s = 4'hF;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    blank_digit_s = ((idx_r == 2'd3) && (snap_r[15:12] == 4'd0)) ||
                    ((idx_r == 2'd2) && (snap_r[15:12] == 4'd0) && (snap_r[11:8] == 4'd0));
`else
    blank_digit_s = 1'b0;
`endif
    if (phase_s == PH_SHOW) begin
      an_nx_s = ~(4'b0001 << idx_r);
      if (blank_digit_s) begin
        seg_nx_s = 7'h7F;
        dp_nx_s  = 1'b1;
      end else begin
        seg_nx_s = bcd_to_seg(digit_s);
        dp_nx_s  = ~idx_r[0];
      end
    end else begin
      an_nx_s  = 4'hF;
      seg_nx_s = 7'h7F;
      dp_nx_s  = 1'b1;
    end
  end

  // Slot counter, digit index, frame snapshot and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      idx_r   <= 2'd0;
      snap_r  <= 16'h0000;
      first_r <= 1'b1;
      seg     <= 7'h7F;
      dp      <= 1'b1;
      an      <= 4'hF;
    end else begin
      first_r <= 1'b0;
      if (wrap_s) begin
        cnt_r <= '0;
        idx_r <= idx_r + 2'd1;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      // A frame only ever shows one counter value.
      if (first_r || (wrap_s && (idx_r == 2'd3))) begin
        snap_r <= {minuto, dec_segundo, uni_segundo, decimo};
      end
      seg <= seg_nx_s;
      dp  <= dp_nx_s;
      an  <= an_nx_s;
    end
  end

endmodule

// File: tb/tb_display_mux_7seg.sv
// Randomised scoreboard bench for display_mux_7seg against a frame/slot arithmetic model.
module tb_display_mux_7seg;

  localparam int R = 4;
  localparam int B = 1;
  localparam int FRAME = 4 * R;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] decimo, uni_segundo, dec_segundo, minuto;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    int         edge_no;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad   = 0;
  int         k     = 0;
  logic [3:0] msnap[4];
  logic [6:0] dec_tab[16];

  display_mux_7seg #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .decimo(decimo), .uni_segundo(uni_segundo),
    .dec_segundo(dec_segundo), .minuto(minuto), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  // Expected output after the coming clock edge, from time since reset release.
  task automatic cyc();
    exp_t e;
    int   c, d;
    logic blank;
    e.seg = 7'h7F; e.dp = 1'b1; e.an = 4'hF;
    if (!rst_n) begin
      k = 0;
    end else begin
      k++;
      c = k - 1;
      if ((c % R) >= B) begin
        d = (c / R) % 4;
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (d == 3 && msnap[3] == 4'd0) blank = 1'b1;
        if (d == 2 && msnap[3] == 4'd0 && msnap[2] == 4'd0) blank = 1'b1;
`endif
        e.an = 4'hF;
        e.an[d] = 1'b0;
        if (!blank) begin
          e.seg = dec_tab[msnap[d]];
          e.dp  = (d == 1 || d == 3) ? 1'b0 : 1'b1;
        end
      end
      if (k == 1 || (k % FRAME) == 0) begin
        msnap[0] = decimo; msnap[1] = uni_segundo;
        msnap[2] = dec_segundo; msnap[3] = minuto;
      end
    end
    e.edge_no = k;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_in(input logic [3:0] m, ds, us, dc);
    minuto = m; dec_segundo = ds; uni_segundo = us; decimo = dc;
  endtask

  // Monitor: one registered output per clock edge, checked against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total++;
        if (seg !== e.seg || dp !== e.dp || an !== e.an) begin
          bad++;
          $display("FAIL out edge=%0d got an=%h seg=%h dp=%b exp an=%h seg=%h dp=%b",
                   e.edge_no, an, seg, dp, e.an, e.seg, e.dp);
        end
      end
    end
  end

  initial begin
    dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
                7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    for (int i = 0; i < 4; i++) msnap[i] = 4'd0;
    rst_n = 1'b0;
    set_in(4'd1, 4'd2, 4'd3, 4'd4);
    run(3);
    rst_n = 1'b1;
    run(FRAME + 2 * R + 2);    // mid-frame, digit 2 slot
    decimo = 4'd5;             // invisible until next frame
    run(2 * FRAME);
    decimo = 4'hB;
    run(2 * FRAME);
    set_in(4'd9, 4'd5, 4'd9, 4'd8);
    // Hold until digit 2 is being shown, then reset asynchronously.
    for (int i = 0; i < 3 * FRAME; i++) begin
      if ((((k - 1) % FRAME) / R) == 2 && ((k - 1) % R) >= B) break;
      cyc();
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      bad++;
      $display("FAIL async_reset got an=%h seg=%h dp=%b exp an=f seg=7f dp=1", an, seg, dp);
    end
    run(2);
    rst_n = 1'b1;
    run(2 * FRAME);
    set_in(4'd0, 4'd0, 4'd7, 4'd3);
    run(2 * FRAME);
    set_in(4'd0, 4'd4, 4'd0, 4'd0);
    run(2 * FRAME);
    // Random traffic, including illegal codes, wrap-cycle changes and resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       decimo      = 4'($urandom_range(0, 15));
          1:       uni_segundo = 4'($urandom_range(0, 15));
          2:       dec_segundo = 4'($urandom_range(0, 15));
          default: minuto      = 4'($urandom_range(0, 2));
        endcase
      end
      if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      cyc();
    end
    rst_n = 1'b1;
    run(4);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain got pending=%0d exp pending=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
